// File: rtl/lev_cmd_pkg.sv
// -----------------------------------------------------------------------------
// lev_cmd_pkg
//   Shared definitions for the levitator phase-array command link. The
//   initiator (lev_cmd_tx) and the board-side decoder both use this package,
//   so the frame layout is defined in exactly one place.
//
//   Frame (3 bytes, sent in order byte0, byte1, byte2):
//     byte0 = {1, op[1:0], ch[6:2]}   -- only byte with bit 7 set (marker)
//     byte1 = {0, ch[1:0], off[11:7]}
//     byte2 = {0, off[6:0]}
//   where off = {enable, offset[10:0]}.
// -----------------------------------------------------------------------------
package lev_cmd_pkg;

    typedef enum logic [1:0] {
        OP_SET_OFFSET = 2'b00,
        OP_RELOAD     = 2'b01,
        OP_QUERY      = 2'b10,
        OP_PROBE      = 2'b11
    } lev_op_e;

    // Field widths on the wire.
    localparam int unsigned LEV_CH_W       = 7;
    localparam int unsigned LEV_OFF_W      = 12;

    // Byte0 marker bit; the decoder resynchronises on it.
    localparam int unsigned LEV_MARKER_BIT = 7;
    // Op code position inside byte0.
    localparam int unsigned LEV_B0_OP_LSB  = 5;
    // Channel split: ch[6:2] rides in byte0, ch[1:0] in byte1 at this LSB.
    localparam int unsigned LEV_CH_SPLIT   = 2;
    localparam int unsigned LEV_B1_CH_LSB  = 5;
    // Offset split: off[11:7] rides in byte1, off[6:0] in byte2.
    localparam int unsigned LEV_OFF_SPLIT  = 7;

    // Whole frame, byte0 in the top 8 bits.
    function automatic logic [23:0] lev_cmd_frame(
        input lev_op_e              op,
        input logic [LEV_CH_W-1:0]  ch,
        input logic [LEV_OFF_W-1:0] off
    );
        logic [23:0] f;
        f = '0;
        // byte0
        f[16 + LEV_MARKER_BIT]     = 1'b1;
        f[16 + LEV_B0_OP_LSB +: 2] = op;
        f[16 +: (LEV_CH_W - LEV_CH_SPLIT)] = ch[LEV_CH_W-1:LEV_CH_SPLIT];
        // byte1
        f[8 + LEV_B1_CH_LSB +: LEV_CH_SPLIT] = ch[LEV_CH_SPLIT-1:0];
        f[8 +: (LEV_OFF_W - LEV_OFF_SPLIT)]  = off[LEV_OFF_W-1:LEV_OFF_SPLIT];
        // byte2
        f[0 +: LEV_OFF_SPLIT] = off[LEV_OFF_SPLIT-1:0];
        return f;
    endfunction

    function automatic logic [7:0] lev_cmd_byte0(
        input lev_op_e              op,
        input logic [LEV_CH_W-1:0]  ch,
        input logic [LEV_OFF_W-1:0] off
    );
        logic [23:0] f;
        f = lev_cmd_frame(op, ch, off);
        return f[23:16];
    endfunction

    function automatic logic [7:0] lev_cmd_byte1(
        input lev_op_e              op,
        input logic [LEV_CH_W-1:0]  ch,
        input logic [LEV_OFF_W-1:0] off
    );
        logic [23:0] f;
        f = lev_cmd_frame(op, ch, off);
        return f[15:8];
    endfunction

    function automatic logic [7:0] lev_cmd_byte2(
        input lev_op_e              op,
        input logic [LEV_CH_W-1:0]  ch,
        input logic [LEV_OFF_W-1:0] off
    );
        logic [23:0] f;
        f = lev_cmd_frame(op, ch, off);
        return f[7:0];
    endfunction

endpackage

// File: rtl/lev_cmd_tx.sv
// -----------------------------------------------------------------------------
// lev_cmd_tx
//   Command initiator for the levitator phase-array link. Accepts one command
//   per cmd_valid/cmd_ready handshake, encodes it into the 3-byte frame and
//   streams it out on an AXI-stream byte port toward a UART transmitter. For
//   query/probe ops it then waits (bounded by RESP_TIMEOUT) for one reply byte
//   from the UART receiver.
//
//   Parameters
//     OUTPUTS       channel count on the target board (range check bound)
//     OFFSET_WIDTH  phase offset width; wire field is OFFSET_WIDTH+1 bits
//     RESP_TIMEOUT  cycles allowed for the reply byte
//
//   Ports
//     clk, rst                 clock, synchronous active-high reset
//     cmd_valid/cmd_ready      command handshake (ready only while idle)
//     cmd_op/channel/enable/offset  command fields, captured at accept
//     output_axis_*            frame bytes to UART TX (tvalid/tdata registered)
//     input_axis_*             reply bytes from UART RX (tready = 1 out of reset)
//     cmd_done                 pulse: frame sent / reply received / timeout
//     cmd_error                pulse: set-offset with out-of-range channel
//     resp_valid, resp_data    pulse + reply byte (data held until next reply)
//     resp_timeout             pulse: no reply in time, resp_data cleared
//     stray_byte               pulse: RX byte outside the reply window
// -----------------------------------------------------------------------------
module lev_cmd_tx
    import lev_cmd_pkg::*;
#(
    parameter int unsigned OUTPUTS      = 88,
    parameter int unsigned OFFSET_WIDTH = 11,
    parameter int unsigned RESP_TIMEOUT = 50000
) (
    input  logic                    clk,
    input  logic                    rst,

    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic [1:0]              cmd_op,
    input  logic [6:0]              cmd_channel,
    input  logic                    cmd_enable,
    input  logic [OFFSET_WIDTH-1:0] cmd_offset,

    output logic [7:0]              output_axis_tdata,
    output logic                    output_axis_tvalid,
    input  logic                    output_axis_tready,

    input  logic [7:0]              input_axis_tdata,
    input  logic                    input_axis_tvalid,
    output logic                    input_axis_tready,

    output logic                    cmd_done,
    output logic                    cmd_error,
    output logic                    resp_valid,
    output logic [7:0]              resp_data,
    output logic                    resp_timeout,
    output logic                    stray_byte
);

    // Sized so RESP_TIMEOUT itself is representable; the counter never wraps.
    localparam int unsigned TIMER_W = $clog2(RESP_TIMEOUT + 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEND0,
        ST_SEND1,
        ST_SEND2,
        ST_WAIT_RESP
    } state_e;

    state_e                 state_q, state_d;
    lev_op_e                op_q, op_d;
    logic [LEV_CH_W-1:0]    ch_q, ch_d;
    logic [LEV_OFF_W-1:0]   off_q, off_d;
    logic [TIMER_W-1:0]     timer_q, timer_d;

    logic [7:0]             tdata_q, tdata_d;
    logic                   tvalid_q, tvalid_d;
    logic                   cmd_ready_q, cmd_ready_d;
    logic                   cmd_done_q, cmd_done_d;
    logic                   cmd_error_q, cmd_error_d;
    logic                   resp_valid_q, resp_valid_d;
    logic [7:0]             resp_data_q, resp_data_d;
    logic                   resp_timeout_q, resp_timeout_d;
    logic                   stray_q, stray_d;

    // Combinational helpers.
    lev_op_e                op_in;
    logic [LEV_CH_W-1:0]    ch_in;
    logic [LEV_OFF_W-1:0]   off_in;
    logic                   accept;
    logic                   ch_bad;
    logic                   tx_hs;
    logic                   rx_hs;

    // Receiver is always ready once out of reset; bytes are never back-pressured.
    assign input_axis_tready = ~rst;

    always_comb begin
        op_in  = lev_op_e'(cmd_op);
        // Non-write ops carry ch = 0 and off = 0 on the wire.
        ch_in  = (op_in == OP_SET_OFFSET) ? cmd_channel : '0;
        off_in = (op_in == OP_SET_OFFSET) ?
                 LEV_OFF_W'({cmd_enable, cmd_offset}) : '0;
        ch_bad = (op_in == OP_SET_OFFSET) && (32'(cmd_channel) >= OUTPUTS);
        accept = cmd_valid && cmd_ready_q;
        tx_hs  = tvalid_q && output_axis_tready;
        rx_hs  = input_axis_tvalid && input_axis_tready;
    end

    always_comb begin
        state_d        = state_q;
        op_d           = op_q;
        ch_d           = ch_q;
        off_d          = off_q;
        timer_d        = timer_q;
        tdata_d        = tdata_q;
        tvalid_d       = tvalid_q;
        cmd_ready_d    = cmd_ready_q;
        resp_data_d    = resp_data_q;
        cmd_done_d     = 1'b0;
        cmd_error_d    = 1'b0;
        resp_valid_d   = 1'b0;
        resp_timeout_d = 1'b0;
        stray_d        = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    if (ch_bad) begin
                        cmd_error_d = 1'b1;
                    end else begin
                        op_d        = op_in;
                        ch_d        = ch_in;
                        off_d       = off_in;
                        // byte0 is built from the live inputs so it is on
                        // the bus the cycle after accept.
                        tdata_d     = lev_cmd_byte0(op_in, ch_in, off_in);
                        tvalid_d    = 1'b1;
                        cmd_ready_d = 1'b0;
                        state_d     = ST_SEND0;
                    end
                end
            end

            ST_SEND0: begin
                if (tx_hs) begin
                    tdata_d = lev_cmd_byte1(op_q, ch_q, off_q);
                    state_d = ST_SEND1;
                end
            end

            ST_SEND1: begin
                if (tx_hs) begin
                    tdata_d = lev_cmd_byte2(op_q, ch_q, off_q);
                    state_d = ST_SEND2;
                end
            end

            ST_SEND2: begin
                if (tx_hs) begin
                    tvalid_d = 1'b0;
                    tdata_d  = '0;
                    if (op_q == OP_SET_OFFSET || op_q == OP_RELOAD) begin
                        cmd_done_d  = 1'b1;
                        cmd_ready_d = 1'b1;
                        state_d     = ST_IDLE;
                    end else begin
                        timer_d = '0;
                        state_d = ST_WAIT_RESP;
                    end
                end
            end

            ST_WAIT_RESP: begin
                // A reply on the expiry cycle takes priority over the timeout.
                if (rx_hs) begin
                    resp_data_d  = input_axis_tdata;
                    resp_valid_d = 1'b1;
                    cmd_done_d   = 1'b1;
                    cmd_ready_d  = 1'b1;
                    state_d      = ST_IDLE;
                end else if (timer_q == TIMER_W'(RESP_TIMEOUT - 1)) begin
                    resp_data_d    = '0;
                    resp_timeout_d = 1'b1;
                    cmd_done_d     = 1'b1;
                    cmd_ready_d    = 1'b1;
                    state_d        = ST_IDLE;
                end else begin
                    timer_d = timer_q + TIMER_W'(1);
                end
            end

            default: begin
                state_d     = ST_IDLE;
                tvalid_d    = 1'b0;
                cmd_ready_d = 1'b1;
            end
        endcase

        if (rx_hs && state_q != ST_WAIT_RESP) begin
            stray_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            op_q           <= OP_SET_OFFSET;
            ch_q           <= '0;
            off_q          <= '0;
            timer_q        <= '0;
            tdata_q        <= '0;
            tvalid_q       <= 1'b0;
            cmd_ready_q    <= 1'b1;
            cmd_done_q     <= 1'b0;
            cmd_error_q    <= 1'b0;
            resp_valid_q   <= 1'b0;
            resp_data_q    <= '0;
            resp_timeout_q <= 1'b0;
            stray_q        <= 1'b0;
        end else begin
            state_q        <= state_d;
            op_q           <= op_d;
            ch_q           <= ch_d;
            off_q          <= off_d;
            timer_q        <= timer_d;
            tdata_q        <= tdata_d;
            tvalid_q       <= tvalid_d;
            cmd_ready_q    <= cmd_ready_d;
            cmd_done_q     <= cmd_done_d;
            cmd_error_q    <= cmd_error_d;
            resp_valid_q   <= resp_valid_d;
            resp_data_q    <= resp_data_d;
            resp_timeout_q <= resp_timeout_d;
            stray_q        <= stray_d;
        end
    end

    assign cmd_ready          = cmd_ready_q;
    assign output_axis_tdata  = tdata_q;
    assign output_axis_tvalid = tvalid_q;
    assign cmd_done           = cmd_done_q;
    assign cmd_error          = cmd_error_q;
    assign resp_valid         = resp_valid_q;
    assign resp_data          = resp_data_q;
    assign resp_timeout       = resp_timeout_q;
    assign stray_byte         = stray_q;

endmodule

// File: tb/tb_lev_cmd_tx.sv
// -----------------------------------------------------------------------------
// tb_lev_cmd_tx
//   Self-checking bench for lev_cmd_tx. Expected frame bytes and reply events
//   are pushed into queues when stimulus is driven; a negedge monitor pops and
//   compares them when the DUT presents them. Directed timing checks run in
//   the main stimulus thread. RESP_TIMEOUT is shortened to 16.
// -----------------------------------------------------------------------------
module tb_lev_cmd_tx;

    localparam int unsigned RT = 16;

    logic        clk = 1'b0;
    logic        rst;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [6:0]  cmd_channel;
    logic        cmd_enable;
    logic [10:0] cmd_offset;
    logic [7:0]  output_axis_tdata;
    logic        output_axis_tvalid;
    logic        output_axis_tready;
    logic [7:0]  input_axis_tdata;
    logic        input_axis_tvalid;
    logic        input_axis_tready;
    logic        cmd_done;
    logic        cmd_error;
    logic        resp_valid;
    logic [7:0]  resp_data;
    logic        resp_timeout;
    logic        stray_byte;

    lev_cmd_tx #(
        .OUTPUTS      (88),
        .OFFSET_WIDTH (11),
        .RESP_TIMEOUT (RT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .cmd_op             (cmd_op),
        .cmd_channel        (cmd_channel),
        .cmd_enable         (cmd_enable),
        .cmd_offset         (cmd_offset),
        .output_axis_tdata  (output_axis_tdata),
        .output_axis_tvalid (output_axis_tvalid),
        .output_axis_tready (output_axis_tready),
        .input_axis_tdata   (input_axis_tdata),
        .input_axis_tvalid  (input_axis_tvalid),
        .input_axis_tready  (input_axis_tready),
        .cmd_done           (cmd_done),
        .cmd_error          (cmd_error),
        .resp_valid         (resp_valid),
        .resp_data          (resp_data),
        .resp_timeout       (resp_timeout),
        .stray_byte         (stray_byte)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] data;
        bit         is_timeout;
    } resp_t;

    logic [7:0] exp_bytes[$];
    resp_t      exp_resp[$];

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference encoder written arithmetically, independent of the package.
    function automatic logic [7:0] model_byte(input int idx, input int op, input int ch,
                                              input int en, input int off);
        int c;
        int o;
        c = (op == 0) ? ch : 0;
        o = (op == 0) ? (en * 2048 + off) : 0;
        case (idx)
            0:       return 8'(128 + op * 32 + c / 4);
            1:       return 8'((c % 4) * 32 + o / 128);
            default: return 8'(o % 128);
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one command for one cycle, then scrambles the command fields to
    // show the DUT works from its captured copy. Returns at T+1 (+1ns).
    task automatic send_cmd(input int op, input int ch, input int en, input int off);
        cmd_valid   = 1'b1;
        cmd_op      = 2'(op);
        cmd_channel = 7'(ch);
        cmd_enable  = 1'(en);
        cmd_offset  = 11'(off);
        if (!(op == 0 && ch >= 88)) begin
            for (int i = 0; i < 3; i++) exp_bytes.push_back(model_byte(i, op, ch, en, off));
        end
        tick();
        cmd_valid   = 1'b0;
        cmd_op      = 2'($urandom);
        cmd_channel = 7'($urandom);
        cmd_enable  = 1'($urandom);
        cmd_offset  = 11'($urandom);
    endtask

    task automatic wait_done(input string tag, input int max_cycles, input bit rand_ready);
        bit seen;
        seen = 0;
        for (int i = 0; i < max_cycles && !seen; i++) begin
            if (rand_ready) output_axis_tready = 1'($urandom_range(0, 1));
            tick();
            if (cmd_done) seen = 1;
        end
        output_axis_tready = 1'b1;
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    // Scoreboard monitor, sampled on the falling edge.
    bit prev_stall = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 0;
        end else begin
            if (prev_stall) check("tvalid_hold", 32'(output_axis_tvalid), 32'd1);
            prev_stall = output_axis_tvalid && !output_axis_tready;
            if (output_axis_tvalid && output_axis_tready) begin
                if (exp_bytes.size() == 0) begin
                    check("unexpected_byte", 32'(output_axis_tdata), 32'h1ff);
                end else begin
                    check("tx_byte", 32'(output_axis_tdata), 32'(exp_bytes.pop_front()));
                end
            end
            if (resp_valid || resp_timeout) begin
                if (exp_resp.size() == 0) begin
                    check("unexpected_resp", 32'(resp_data), 32'h1ff);
                end else begin
                    resp_t r;
                    r = exp_resp.pop_front();
                    check("resp_data", 32'(resp_data), 32'(r.data));
                    check("resp_kind", {30'd0, resp_timeout, resp_valid},
                          r.is_timeout ? 32'd2 : 32'd1);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst                = 1'b1;
        cmd_valid          = 1'b0;
        cmd_op             = '0;
        cmd_channel        = '0;
        cmd_enable         = 1'b0;
        cmd_offset         = '0;
        output_axis_tready = 1'b1;
        input_axis_tdata   = '0;
        input_axis_tvalid  = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_tvalid", 32'(output_axis_tvalid), 32'd0);
        check("rst_tdata", 32'(output_axis_tdata), 32'd0);
        check("rst_resp_data", 32'(resp_data), 32'd0);
        check("rst_pulses", {26'd0, cmd_done, cmd_error, resp_valid, resp_timeout, stray_byte, 1'b0}, 32'd0);
        rst = 1'b0;
        #1;
        check("rx_tready", 32'(input_axis_tready), 32'd1);
        tick();

        // Write: op 0, ch 5, enable 1, offset 0x123
        send_cmd(0, 5, 1, 'h123);
        check("w_b0", 32'(output_axis_tdata), 32'h81);
        check("w_tvalid", 32'(output_axis_tvalid), 32'd1);
        check("w_ready_lo", 32'(cmd_ready), 32'd0);
        tick();
        check("w_b1", 32'(output_axis_tdata), 32'h32);
        tick();
        check("w_b2", 32'(output_axis_tdata), 32'h23);
        check("w_no_done", 32'(cmd_done), 32'd0);
        tick();
        check("w_done_t4", 32'(cmd_done), 32'd1);
        check("w_ready_t4", 32'(cmd_ready), 32'd1);
        check("w_tvalid_off", 32'(output_axis_tvalid), 32'd0);
        tick();
        check("w_done_pulse", 32'(cmd_done), 32'd0);

        // Reload with a 3-cycle stall on byte1
        send_cmd(1, 0, 0, 0);
        check("rl_b0", 32'(output_axis_tdata), 32'hA0);
        tick();
        output_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("rl_stall_tdata", 32'(output_axis_tdata), 32'h00);
            check("rl_stall_tvalid", 32'(output_axis_tvalid), 32'd1);
            check("rl_no_resp", {30'd0, resp_valid, resp_timeout}, 32'd0);
            tick();
        end
        output_axis_tready = 1'b1;
        wait_done("rl", 10, 0);
        check("rl_no_resp_end", {30'd0, resp_valid, resp_timeout}, 32'd0);

        // Query: reply 0x58 injected 9 cycles into WAIT_RESP
        tick();
        send_cmd(2, 0, 0, 0);
        repeat (3) tick();
        check("q_wait_tvalid", 32'(output_axis_tvalid), 32'd0);
        check("q_wait_ready", 32'(cmd_ready), 32'd0);
        repeat (9) tick();
        check("q_still_wait", 32'(cmd_done), 32'd0);
        input_axis_tdata  = 8'h58;
        input_axis_tvalid = 1'b1;
        exp_resp.push_back('{data: 8'h58, is_timeout: 0});
        tick();
        input_axis_tvalid = 1'b0;
        check("q_resp_valid", 32'(resp_valid), 32'd1);
        check("q_done", 32'(cmd_done), 32'd1);
        check("q_resp_data", 32'(resp_data), 32'h58);
        check("q_no_stray", 32'(stray_byte), 32'd0);
        tick();
        check("q_data_held", 32'(resp_data), 32'h58);

        // Probe with no reply: timeout 16 cycles after entering WAIT_RESP
        send_cmd(3, 0, 0, 0);
        repeat (3) tick();
        exp_resp.push_back('{data: 8'h00, is_timeout: 1});
        for (int i = 0; i < 15; i++) begin
            tick();
            check("to_early", {30'd0, resp_timeout, cmd_done}, 32'd0);
        end
        tick();
        check("to_pulse", 32'(resp_timeout), 32'd1);
        check("to_done", 32'(cmd_done), 32'd1);
        check("to_data", 32'(resp_data), 32'd0);
        check("to_no_valid", 32'(resp_valid), 32'd0);

        // Probe with reply on the expiry cycle: reply wins
        tick();
        send_cmd(3, 0, 0, 0);
        repeat (3) tick();
        repeat (15) tick();
        input_axis_tdata  = 8'hC3;
        input_axis_tvalid = 1'b1;
        exp_resp.push_back('{data: 8'hC3, is_timeout: 0});
        tick();
        input_axis_tvalid = 1'b0;
        check("edge_valid", 32'(resp_valid), 32'd1);
        check("edge_no_to", 32'(resp_timeout), 32'd0);
        check("edge_data", 32'(resp_data), 32'hC3);
        check("edge_done", 32'(cmd_done), 32'd1);

        // Out-of-range channel 88: error, nothing sent
        tick();
        send_cmd(0, 88, 1, 'h7FF);
        check("err_pulse", 32'(cmd_error), 32'd1);
        check("err_ready", 32'(cmd_ready), 32'd1);
        check("err_no_tvalid", 32'(output_axis_tvalid), 32'd0);
        tick();
        check("err_pulse_end", 32'(cmd_error), 32'd0);
        check("err_still_idle", 32'(output_axis_tvalid), 32'd0);

        // Boundary channel 87 is accepted
        send_cmd(0, 87, 0, 'h7FF);
        check("ch87_no_err", 32'(cmd_error), 32'd0);
        wait_done("ch87", 10, 0);

        // Stray byte while idle
        tick();
        input_axis_tdata  = 8'h11;
        input_axis_tvalid = 1'b1;
        tick();
        input_axis_tvalid = 1'b0;
        check("stray_pulse", 32'(stray_byte), 32'd1);
        check("stray_no_resp", 32'(resp_valid), 32'd0);
        check("stray_data_kept", 32'(resp_data), 32'hC3);
        tick();
        check("stray_pulse_end", 32'(stray_byte), 32'd0);

        // Reset while byte1 is pending
        send_cmd(0, 10, 1, 'h055);
        tick();
        output_axis_tready = 1'b0;
        check("mid_b1_valid", 32'(output_axis_tvalid), 32'd1);
        rst = 1'b1;
        tick();
        check("mid_rst_tvalid", 32'(output_axis_tvalid), 32'd0);
        check("mid_rst_ready", 32'(cmd_ready), 32'd1);
        check("mid_rst_tdata", 32'(output_axis_tdata), 32'd0);
        exp_bytes.delete();
        rst = 1'b0;
        output_axis_tready = 1'b1;
        tick();
        send_cmd(1, 0, 0, 0);
        check("post_rst_b0", 32'(output_axis_tdata), 32'hA0);
        wait_done("post_rst", 10, 0);

        // Random writes/reloads with random tready stalls
        for (int n = 0; n < 6; n++) begin
            tick();
            send_cmd($urandom_range(0, 1), $urandom_range(0, 87), $urandom_range(0, 1),
                     $urandom_range(0, 2047));
            wait_done("rnd", 80, 1);
        end

        repeat (3) tick();
        check("bytes_drained", 32'(exp_bytes.size()), 32'd0);
        check("resp_drained", 32'(exp_resp.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
